// File: rtl/btn_pkg.sv
// Shared button-conditioning definitions: FSM encodings, debounce timing constants
// and the stable-counter width helper.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } btn_state_t;

    // 10 ms at 100 MHz.
    localparam int STABLE_CYCLES_DEFAULT = 1000000;
    localparam int STABLE_CYCLES_SIM     = 4;

    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit; 2-cycle latency, no backpressure.
// Resets to 0 asynchronously.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic sync_q
);

    logic meta_q;
    logic meta_d;
    logic sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

endmodule

// File: rtl/btn_debouncer.sv
// Push-button debouncer: sync, stable-time FSM, clean level, press/release pulses, press counter.
// Level changes STABLE_CYCLES+3 edges after a stable input change; no backpressure.
module btn_debouncer
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             cnt_clr,
    output logic             btn_level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int            CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic sync_q;

    sync_2ff u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_in   (btn_in),
        .sync_q (sync_q)
    );

    btn_state_t       state_q, state_d;
    logic [CW-1:0]    stab_cnt_q, stab_cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

    always_comb begin
        state_d     = state_q;
        stab_cnt_d  = stab_cnt_q;
        level_d     = level_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        press_cnt_d = press_cnt_q;

        case (state_q)
            S_LOW: begin
                if (sync_q) begin
                    state_d    = S_WAIT_HIGH;
                    stab_cnt_d = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!sync_q) begin
                    state_d = S_LOW;
                end else if (stab_cnt_q == CNT_MAX) begin
                    state_d = S_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + CW'(1);
                end
            end
            S_HIGH: begin
                if (!sync_q) begin
                    state_d    = S_WAIT_LOW;
                    stab_cnt_d = '0;
                end
            end
            S_WAIT_LOW: begin
                if (sync_q) begin
                    state_d = S_HIGH;
                end else if (stab_cnt_q == CNT_MAX) begin
                    state_d = S_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + CW'(1);
                end
            end
            default: state_d = S_LOW;
        endcase

        // Clear takes priority over a coincident accepted press.
        if (rise_d) begin
            press_cnt_d = press_cnt_q + CNT_W'(1);
        end
        if (cnt_clr) begin
            press_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOW;
            stab_cnt_q  <= '0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign btn_level   = level_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign press_count = press_cnt_q;

endmodule
